// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, FSM state encoding and
// the test that routes an opcode to the iterative multiplier/divider.
package alu_seq_pkg;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_AND   = 4'd2;
    localparam logic [3:0] ALU_OP_OR    = 4'd3;
    localparam logic [3:0] ALU_OP_XOR   = 4'd4;
    localparam logic [3:0] ALU_OP_SLL   = 4'd5;
    localparam logic [3:0] ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] ALU_OP_SLT   = 4'd8;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd9;
    localparam logic [3:0] ALU_OP_MUL   = 4'd10;
    localparam logic [3:0] ALU_OP_MULHU = 4'd11;
    localparam logic [3:0] ALU_OP_DIVU  = 4'd12;
    localparam logic [3:0] ALU_OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the execute stage and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op_0;
    logic [WIDTH-1:0] op_1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ZERO;
    logic             NEGATIVE;
    logic             CARRY;
    logic             OVERFLOW;
    logic             busy;

    modport master (
        output in_valid, opcode, op_0, op_1, out_ready,
        input  in_ready, out_valid, out, ZERO, NEGATIVE, CARRY, OVERFLOW, busy
    );

    modport slave (
        input  in_valid, opcode, op_0, op_1, out_ready,
        output in_ready, out_valid, out, ZERO, NEGATIVE, CARRY, OVERFLOW, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiply and restoring unsigned divide,
// one step per cycle, sharing a single 2*WIDTH accumulator.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_op_0,
    input  logic [WIDTH-1:0] i_op_1,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_part;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_acc_next;

    // Multiply: high half accumulates, low half holds the remaining multiplier.
    // Divide: high half is the partial remainder, low half collects quotient bits.
    always_comb begin
        w_is_mul = (r_op == ALU_OP_MUL) || (r_op == ALU_OP_MULHU);
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
        w_part   = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge     = w_part >= {1'b0, r_opb};
        w_rem    = w_part[WIDTH-1:0] - r_opb;
        if (w_is_mul) begin
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end else if (w_ge) begin
            w_acc_next = {w_rem, r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_next = {w_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_op     <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_active <= 1'b1;
            r_op     <= i_opcode;
            r_opb    <= i_op_1;
            r_acc    <= {{WIDTH{1'b0}}, i_op_0};
        end else if (r_active) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= w_acc_next;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done   = r_active && (r_cnt == '0);
    assign o_result = ((r_op == ALU_OP_MULHU) || (r_op == ALU_OP_REMU)) ?
                      r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle ops complete in one cycle,
// MUL/MULHU/DIVU/REMU stall the handshake while the iterative unit runs.
//
// state | meaning
// IDLE  | no result held, ready for operands
// ITER  | iterative mul/div running, busy, not ready
// DONE  | result and flags valid, waiting for consumer
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;

    logic               w_accept;
    logic               w_start;
    logic               w_load;
    logic               w_md_done;
    logic [WIDTH-1:0]   w_md_result;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;
    logic               w_alu_ovf;
    logic               w_is_sub;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_res_next;

    assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_start       = w_accept && is_multicycle(bus.opcode);
    assign w_load        = (w_accept && !is_multicycle(bus.opcode)) ||
                           ((r_state == ST_ITER) && w_md_done);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_ITER);
    assign bus.out       = r_out;
    assign bus.ZERO      = r_zero;
    assign bus.NEGATIVE  = r_neg;
    assign bus.CARRY     = r_carry;
    assign bus.OVERFLOW  = r_ovf;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_opcode (bus.opcode),
        .i_op_0   (bus.op_0),
        .i_op_1   (bus.op_1),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // SUB shares the adder as op_0 + ~op_1 + 1 so CARRY means "no borrow".
    always_comb begin
        w_is_sub    = (bus.opcode == ALU_OP_SUB);
        w_b         = w_is_sub ? ~bus.op_1 : bus.op_1;
        w_sum       = {1'b0, bus.op_0} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_is_sub};
        w_shamt     = bus.op_1[SHAMT_W-1:0];
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_res   = '0;
        case (bus.opcode)
            ALU_OP_ADD, ALU_OP_SUB: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (bus.op_0[WIDTH-1] == w_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != bus.op_0[WIDTH-1]);
            end
            ALU_OP_AND:  w_alu_res = bus.op_0 & bus.op_1;
            ALU_OP_OR:   w_alu_res = bus.op_0 | bus.op_1;
            ALU_OP_XOR:  w_alu_res = bus.op_0 ^ bus.op_1;
            ALU_OP_SLL:  w_alu_res = bus.op_0 << w_shamt;
            ALU_OP_SRL:  w_alu_res = bus.op_0 >> w_shamt;
            ALU_OP_SRA:  w_alu_res = $signed(bus.op_0) >>> w_shamt;
            ALU_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_0) < $signed(bus.op_1))};
            ALU_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.op_0 < bus.op_1)};
            default:     w_alu_res = '0;
        endcase
    end

    assign w_res_next = (r_state == ST_ITER) ? w_md_result : w_alu_res;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = is_multicycle(bus.opcode) ? ST_ITER : ST_DONE;
                end
            end
            ST_ITER: begin
                if (w_md_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_state_next = is_multicycle(bus.opcode) ? ST_ITER : ST_DONE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_out   <= w_res_next;
                r_zero  <= (w_res_next == '0);
                r_neg   <= w_res_next[WIDTH-1];
                r_carry <= (r_state == ST_ITER) ? 1'b0 : w_alu_carry;
                r_ovf   <= (r_state == ST_ITER) ? 1'b0 : w_alu_ovf;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   lat;
    bit   stall_ok;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.op_0     = a;
        bus.op_1     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_0     = 32'hDEAD_BEEF;
        bus.op_1     = 32'h1234_5678;
    endtask

    // Count cycles from the accept edge until out_valid; busy/in_ready must show the stall.
    task automatic wait_result(output int latency, output bit ok);
        latency = 0;
        ok      = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                latency = k;
                break;
            end
            if (!(bus.busy && !bus.in_ready)) ok = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.op_0      = '0;
        bus.op_1      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out", bus.out, 0);
        chk("rst_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b1000);

        send(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_valid", bus.out_valid, 1);
        chk("add_out", bus.out, 64'h8000_0000);
        chk("add_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b0101);

        send(ALU_OP_SUB, 32'd5, 32'd5);
        chk("sub_eq_out", bus.out, 0);
        chk("sub_eq_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b1010);
        send(ALU_OP_SUB, 32'd3, 32'd5);
        chk("sub_lt_out", bus.out, 64'hFFFF_FFFE);
        chk("sub_lt_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b0100);
        send(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h1);
        chk("add_carry_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b1010);
        send(ALU_OP_SLT, 32'hFFFF_FFFF, 32'h1);
        chk("slt_out", bus.out, 1);
        send(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        chk("sltu_out", bus.out, 0);
        send(ALU_OP_XOR, 32'hF0F0_1234, 32'h0FF0_1234);
        chk("xor_out", bus.out, 64'hFF00_0000);
        send(ALU_OP_SRL, 32'h8000_0000, 32'd4);
        chk("srl_out", bus.out, 64'h0800_0000);
        @(posedge clk);
        #1;
        chk("idle_after_drain", bus.out_valid, 0);

        send(ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_busy_after_accept", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
        wait_result(lat, stall_ok);
        chk("mul_latency", lat, 33);
        chk("mul_stall", stall_ok, 1);
        chk("mul_out", bus.out, 1);
        chk("mul_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b0000);

        send(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, stall_ok);
        chk("mulhu_latency", lat, 33);
        chk("mulhu_stall", stall_ok, 1);
        chk("mulhu_out", bus.out, 64'hFFFF_FFFE);
        chk("mulhu_neg", bus.NEGATIVE, 1);

        send(ALU_OP_DIVU, 32'd100, 32'd7);
        wait_result(lat, stall_ok);
        chk("divu_latency", lat, 33);
        chk("divu_out", bus.out, 14);
        send(ALU_OP_REMU, 32'd100, 32'd7);
        wait_result(lat, stall_ok);
        chk("remu_out", bus.out, 2);
        send(ALU_OP_DIVU, 32'd9, 32'd0);
        wait_result(lat, stall_ok);
        chk("divu0_latency", lat, 33);
        chk("divu0_out", bus.out, 64'hFFFF_FFFF);
        send(ALU_OP_REMU, 32'd9, 32'd0);
        wait_result(lat, stall_ok);
        chk("remu0_out", bus.out, 9);
        send(ALU_OP_MUL, 32'd12345, 32'd1000);
        wait_result(lat, stall_ok);
        chk("mul_small_out", bus.out, 12345000);

        send(ALU_OP_SRA, 32'h8000_0000, 32'd4);
        chk("sra_out", bus.out, 64'hF800_0000);
        chk("sra_valid", bus.out_valid, 1);
        send(ALU_OP_SLL, 32'h1, 32'd35);
        chk("sll_b2b_out", bus.out, 8);
        chk("sll_b2b_valid", bus.out_valid, 1);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opcode    = ALU_OP_ADD;
        bus.op_0      = 32'd1;
        bus.op_1      = 32'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
            chk("hold_out", {bus.out_valid, bus.out}, {1'b1, 32'h8});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_idle", bus.out_valid, 0);

        send(ALU_OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_state", {bus.out_valid, bus.busy, bus.ZERO, bus.in_ready}, 4'b0011);
        chk("mid_rst_out", bus.out, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_no_result", bus.out_valid, 0);

        send(ALU_OP_ADD, 32'd2, 32'd3);
        chk("add_after_rst", bus.out, 5);
        chk("add_after_rst_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b0000);
        send(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("reserved_out", {bus.out_valid, bus.out}, {1'b1, 32'h0});
        chk("reserved_flags", {bus.ZERO, bus.NEGATIVE, bus.CARRY, bus.OVERFLOW}, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
